seq_divider: RTL and testbench

Multi-cycle unsigned integer divider producing quotient and remainder by restoring division, one quotient bit per clock. It shares the adder/subtractor datapath style of the arithmetic blocks and performs the inverse operation of repeated addition. A host drives a start/done handshake, and the block sits beside the combinational adders as the slow-path arithmetic unit.

---
 rtl/seq_divider.sv | 121 ++++++++++++
 tb/tb_seq_divider.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, start/done handshake.
// Divide-by-zero completes in one cycle with an all-ones quotient and the dividend as remainder.
module seq_divider #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         div_zero
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t state, state_next;

    logic [W-1:0]  q;
    logic [W-1:0]  d;
    logic [W:0]    r;
    logic [CW-1:0] cnt;

    logic [W:0]   r_shift;
    logic [W:0]   trial;
    logic [W:0]   r_step;
    logic [W-1:0] q_step;
    logic         accept;
    logic         last_step;

    // One restoring step; a set MSB of the trial difference means the divisor did not fit.
    always_comb begin
        r_shift = {r[W-1:0], q[W-1]};
        trial   = r_shift + {1'b1, ~d} + (W+1)'(1);
        if (trial[W]) begin
            r_step = r_shift;
            q_step = {q[W-2:0], 1'b0};
        end else begin
            r_step = trial;
            q_step = {q[W-2:0], 1'b1};
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last_step  = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = (divisor == '0) ? DONE : CALC;
                end else begin
                    state_next = IDLE;
                end
            end
            CALC: begin
                if (cnt == CW'(W - 1)) begin
                    last_step  = 1'b1;
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // busy/done are registered copies of the next state so no input reaches an output combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            q         <= '0;
            d         <= '0;
            r         <= '0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else begin
            busy <= (state_next == CALC);
            done <= (state_next == DONE);
            if (accept && (divisor != '0)) begin
                q   <= dividend;
                r   <= '0;
                d   <= divisor;
                cnt <= '0;
            end else if (accept) begin
                quotient  <= '1;
                remainder <= dividend;
                div_zero  <= 1'b1;
            end else if (state == CALC) begin
                q   <= q_step;
                r   <= r_step;
                cnt <= cnt + 1'b1;
                if (last_step) begin
                    quotient  <= q_step;
                    remainder <= r_step[W-1:0];
                    div_zero  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: expected results are queued when a start is driven
// and compared whenever the divider raises done.
module tb_seq_divider;

    localparam int W = 5;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } result_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_zero;

    int      total = 0;
    int      bad = 0;
    int      done_count = 0;
    result_t expq[$];
    result_t mon_e;

    seq_divider #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, want %0d", tag, observed, expected);
        end
    endtask

    function automatic result_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        result_t e;
        if (b == '0) begin
            e.q  = '1;
            e.r  = a;
            e.dz = 1'b1;
        end else begin
            e.q  = a / b;
            e.r  = a % b;
            e.dz = 1'b0;
        end
        return e;
    endfunction

    // Every done pulse must consume exactly one queued expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_count++;
            checkOutput("busy_in_done", busy, 0);
            checkOutput("done_has_expect", expq.size() != 0, 1);
            if (expq.size() != 0) begin
                mon_e = expq.pop_front();
                checkOutput("quotient", quotient, mon_e.q);
                checkOutput("remainder", remainder, mon_e.r);
                checkOutput("div_zero", div_zero, mon_e.dz);
            end
        end
    end

    // Called on a falling edge; start is sampled on the following rising edge.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input bit accepted);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        if (accepted) expq.push_back(model(a, b));
        @(negedge clk);
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
    endtask

    task automatic waitDone(output int cycles);
        cycles = 1;
        while (done !== 1'b1 && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput("done_seen", done, 1);
    endtask

    task automatic runTimed(input logic [W-1:0] a, input logic [W-1:0] b);
        int      lat;
        int      busy_cycles;
        result_t e;
        e = model(a, b);
        applyStimulus(a, b, 1'b1);
        lat = 1;
        busy_cycles = 0;
        while (done !== 1'b1 && lat < 20) begin
            if (busy === 1'b1) busy_cycles++;
            @(negedge clk);
            lat++;
        end
        checkOutput("done_seen", done, 1);
        checkOutput("latency", lat, (b == '0) ? 1 : W + 1);
        checkOutput("busy_cycles", busy_cycles, (b == '0) ? 0 : W);
        @(negedge clk);
        checkOutput("done_width", done, 0);
        checkOutput("q_held", quotient, e.q);
        checkOutput("r_held", remainder, e.r);
        checkOutput("dz_held", div_zero, e.dz);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int cycles;
        int gap;
        int base;

        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_quotient", quotient, 0);
        checkOutput("rst_remainder", remainder, 0);
        checkOutput("rst_div_zero", div_zero, 0);
        rst_n = 1'b1;
        @(negedge clk);

        runTimed(23, 5);
        runTimed(31, 1);
        runTimed(7, 9);
        runTimed(31, 31);
        runTimed(0, 3);
        runTimed(13, 0);
        runTimed(10, 2);

        // A start pulse during CALC must be ignored.
        base = done_count;
        applyStimulus(23, 5, 1'b1);
        @(negedge clk);
        applyStimulus(30, 3, 1'b0);
        waitDone(cycles);
        repeat (8) @(negedge clk);
        checkOutput("single_done", done_count - base, 1);

        // Back-to-back: second start issued in the DONE cycle.
        applyStimulus(23, 5, 1'b1);
        waitDone(cycles);
        applyStimulus(30, 4, 1'b1);
        gap = 1;
        while (done !== 1'b1 && gap < 20) begin
            @(negedge clk);
            gap++;
        end
        checkOutput("b2b_gap", gap, W + 1);
        @(negedge clk);
        checkOutput("b2b_quotient", quotient, 7);
        checkOutput("b2b_remainder", remainder, 2);

        // Reset asserted on the third CALC cycle discards the operation.
        base = done_count;
        applyStimulus(29, 3, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_done", done, 0);
        checkOutput("midrst_quotient", quotient, 0);
        checkOutput("midrst_remainder", remainder, 0);
        checkOutput("midrst_div_zero", div_zero, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        checkOutput("midrst_no_done", done_count - base, 0);
        runTimed(29, 3);

        checkOutput("sb_drained", expq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
